// File: rtl/pong_pixel_gen.sv
// Pong game core and pixel source: paddles, ball, scores and serve/point/game-over FSM.
// Optional macro CENTER_NET_EN draws a dashed green centre net.
module pong_pixel_gen #(
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int PADDLE_W   = 8,
  parameter int PADDLE_H   = 64,
  parameter int PADDLE_XL  = 16,
  parameter int PADDLE_XR  = 616,
  parameter int BALL_SZ    = 8,
  parameter int BALL_SPD   = 2,
  parameter int PAD_SPD    = 4,
  parameter int MAX_SCORE  = 9,
  parameter int POINT_HOLD = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       blank,
  input  logic       vsync,
  input  logic       btn_l_up,
  input  logic       btn_l_dn,
  input  logic       btn_r_up,
  input  logic       btn_r_dn,
  input  logic       serve,
  output logic       iR,
  output logic       iG,
  output logic       iB,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [1:0] dbg_state_o,
  output logic [9:0] dbg_ball_x_o,
  output logic [9:0] dbg_ball_y_o,
  output logic       dbg_dx_neg_o,
  output logic       dbg_dy_neg_o,
  output logic [9:0] dbg_pad_l_o,
  output logic [9:0] dbg_pad_r_o
);

  typedef enum logic [1:0] {
    S_SERVE = 2'd0,
    S_PLAY  = 2'd1,
    S_POINT = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  localparam int HW = $clog2(POINT_HOLD + 1);

  localparam logic [10:0] SPD11   = 11'(BALL_SPD);
  localparam logic [10:0] SZ11    = 11'(BALL_SZ);
  localparam logic [10:0] SW11    = 11'(SCREEN_W);
  localparam logic [10:0] SH11    = 11'(SCREEN_H);
  localparam logic [10:0] PW11    = 11'(PADDLE_W);
  localparam logic [10:0] PH11    = 11'(PADDLE_H);
  localparam logic [10:0] XL11    = 11'(PADDLE_XL);
  localparam logic [10:0] XR11    = 11'(PADDLE_XR);
  localparam logic [10:0] LFACE11 = 11'(PADDLE_XL + PADDLE_W);

  localparam logic [9:0] SPD10  = 10'(BALL_SPD);
  localparam logic [9:0] CX10   = 10'((SCREEN_W - BALL_SZ) / 2);
  localparam logic [9:0] CY10   = 10'((SCREEN_H - BALL_SZ) / 2);
  localparam logic [9:0] PAD010 = 10'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [9:0] YBOT10 = 10'(SCREEN_H - BALL_SZ);
  localparam logic [9:0] LHIT10 = 10'(PADDLE_XL + PADDLE_W);
  localparam logic [9:0] RHIT10 = 10'(PADDLE_XR - BALL_SZ);

  localparam logic signed [10:0] PSPD_S = 11'(PAD_SPD);
  localparam logic signed [10:0] PMAX_S = 11'(SCREEN_H - PADDLE_H);
  localparam logic [3:0]         MAXS   = 4'(MAX_SCORE);
  localparam logic [HW-1:0]      HLAST  = HW'(POINT_HOLD - 1);

  state_t        state_q;
  logic          vsync_q;
  logic [HW-1:0] hold_q;
  logic [9:0]    pad_l_q, pad_r_q, ball_x_q, ball_y_q;
  logic          dx_neg_q, dy_neg_q;
  logic [3:0]    score_l_q, score_r_q;
  logic [2:0]    rgb_q;

  logic          tick;
  logic [9:0]    pad_l_d, pad_r_d, y_w;
  logic          dy_w;
  logic [10:0]   bx11, by11, pl11, pr11, hx11, vy11;
  logic          ov_l, ov_r, hit_l, hit_r, miss_l, miss_r;
  logic          in_pad, in_ball;
  logic [2:0]    pix_rgb;

  // Signed 11-bit step so moving up from near 0 clamps instead of wrapping.
  function automatic logic [9:0] pad_step(input logic [9:0] y, input logic up, input logic dn);
    logic signed [10:0] t;
    t = $signed({1'b0, y});
    if (up && !dn)      t = t - PSPD_S;
    else if (dn && !up) t = t + PSPD_S;
    if (t < 11'sd0)       t = 11'sd0;
    else if (t > PMAX_S)  t = PMAX_S;
    return t[9:0];
  endfunction

  assign tick    = vsync_q & ~vsync;
  assign pad_l_d = pad_step(pad_l_q, btn_l_up, btn_l_dn);
  assign pad_r_d = pad_step(pad_r_q, btn_r_up, btn_r_dn);

  assign bx11 = {1'b0, ball_x_q};
  assign by11 = {1'b0, ball_y_q};
  assign pl11 = {1'b0, pad_l_q};
  assign pr11 = {1'b0, pad_r_q};
  assign hx11 = {1'b0, hcount};
  assign vy11 = {1'b0, vcount};

  always_comb begin
    y_w  = ball_y_q;
    dy_w = dy_neg_q;
    if (dy_neg_q && by11 < SPD11) begin
      y_w  = '0;
      dy_w = 1'b0;
    end else if (!dy_neg_q && (by11 + SZ11 + SPD11 > SH11)) begin
      y_w  = YBOT10;
      dy_w = 1'b1;
    end else if (dy_neg_q) begin
      y_w = ball_y_q - SPD10;
    end else begin
      y_w = ball_y_q + SPD10;
    end
  end

  // Paddle contact uses the ball position at the start of the tick.
  assign ov_l   = (by11 + SZ11 > pl11) && (by11 < pl11 + PH11);
  assign ov_r   = (by11 + SZ11 > pr11) && (by11 < pr11 + PH11);
  assign hit_l  = dx_neg_q && (bx11 >= LFACE11) && (bx11 - SPD11 < LFACE11) && ov_l;
  assign hit_r  = !dx_neg_q && (bx11 + SZ11 <= XR11) && (bx11 + SZ11 + SPD11 > XR11) && ov_r;
  assign miss_l = dx_neg_q && (bx11 < SPD11);
  assign miss_r = !dx_neg_q && (bx11 + SZ11 + SPD11 > SW11);

  assign in_pad = (vy11 >= pl11 && vy11 < pl11 + PH11 && hx11 >= XL11 && hx11 < XL11 + PW11) ||
                  (vy11 >= pr11 && vy11 < pr11 + PH11 && hx11 >= XR11 && hx11 < XR11 + PW11);
  assign in_ball = (state_q != S_OVER) &&
                   hx11 >= bx11 && hx11 < bx11 + SZ11 && vy11 >= by11 && vy11 < by11 + SZ11;

`ifdef CENTER_NET_EN
  localparam logic [10:0] NETL11 = 11'(SCREEN_W / 2 - 2);
  localparam logic [10:0] NETR11 = 11'(SCREEN_W / 2 + 2);
  logic in_net;
  assign in_net = hx11 >= NETL11 && hx11 < NETR11 && !vcount[4];
  always_comb begin
    pix_rgb = 3'b000;
    if (!blank)                  pix_rgb = 3'b000;
    else if (in_pad || in_ball)  pix_rgb = 3'b111;
    else if (in_net)             pix_rgb = 3'b010;
  end
`else
  always_comb begin
    pix_rgb = 3'b000;
    if (blank && (in_pad || in_ball)) pix_rgb = 3'b111;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_SERVE;
      vsync_q   <= 1'b1;
      hold_q    <= '0;
      pad_l_q   <= PAD010;
      pad_r_q   <= PAD010;
      ball_x_q  <= CX10;
      ball_y_q  <= CY10;
      dx_neg_q  <= 1'b0;
      dy_neg_q  <= 1'b0;
      score_l_q <= '0;
      score_r_q <= '0;
      rgb_q     <= '0;
    end else begin
      vsync_q <= vsync;
      rgb_q   <= pix_rgb;
      if (tick) begin
        if (state_q != S_OVER) begin
          pad_l_q <= pad_l_d;
          pad_r_q <= pad_r_d;
        end
        case (state_q)
          S_SERVE: if (serve) state_q <= S_PLAY;
          S_PLAY: begin
            ball_y_q <= y_w;
            dy_neg_q <= dy_w;
            if (hit_l) begin
              ball_x_q <= LHIT10;
              dx_neg_q <= 1'b0;
            end else if (hit_r) begin
              ball_x_q <= RHIT10;
              dx_neg_q <= 1'b1;
            end else if (miss_l || miss_r) begin
              // The scorer's opponent receives the next serve direction.
              if (miss_l) score_r_q <= score_r_q + 4'd1;
              else        score_l_q <= score_l_q + 4'd1;
              dx_neg_q <= miss_l;
              ball_x_q <= CX10;
              ball_y_q <= CY10;
              hold_q   <= '0;
              state_q  <= S_POINT;
            end else if (dx_neg_q) begin
              ball_x_q <= ball_x_q - SPD10;
            end else begin
              ball_x_q <= ball_x_q + SPD10;
            end
          end
          S_POINT: begin
            hold_q <= hold_q + 1'b1;
            if (hold_q == HLAST)
              state_q <= (score_l_q == MAXS || score_r_q == MAXS) ? S_OVER : S_SERVE;
          end
          S_OVER: begin
            if (serve) begin
              score_l_q <= '0;
              score_r_q <= '0;
              dx_neg_q  <= 1'b0;
              state_q   <= S_SERVE;
            end
          end
          default: state_q <= S_SERVE;
        endcase
      end
    end
  end

  assign {iR, iG, iB}  = rgb_q;
  assign score_l      = score_l_q;
  assign score_r      = score_r_q;
  assign dbg_state_o  = state_q;
  assign dbg_ball_x_o = ball_x_q;
  assign dbg_ball_y_o = ball_y_q;
  assign dbg_dx_neg_o = dx_neg_q;
  assign dbg_dy_neg_o = dy_neg_q;
  assign dbg_pad_l_o  = pad_l_q;
  assign dbg_pad_r_o  = pad_r_q;

endmodule
